hand_feature_extractor: RTL and testbench

- Downstream stage of the Pi image receiver.
- Consumes the LENGTH x WIDTH binary hand mask and its image_ready flag.
- Scans the mask sequentially, one pixel per clock, and produces compact features for the rps classifier: per-row and per-column hand-pixel counts, total count, and bounding box.
- Presents the features with a valid/ack handshake.

---
 rtl/hand_feature_extractor_pkg.sv | 28 ++
 rtl/hand_feature_extractor_pulse_sync_edge.sv | 29 ++
 rtl/hand_feature_extractor.sv | 182 ++++++++++++++++++
 tb/tb_hand_feature_extractor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hand_feature_extractor_pkg.sv
// Shared definitions for the hand feature extractor: default geometry,
// FSM state encoding and small bounding-box helpers.
package hand_feature_extractor_pkg;

    localparam int DEF_LENGTH = 28;
    localparam int DEF_WIDTH  = 28;
    localparam int DEF_CNT_W  = 10;

    // Bounding-box trackers start "inverted" so the first hand pixel wins both.
    localparam logic [4:0] BBOX_MIN_INIT = 5'd31;
    localparam logic [4:0] BBOX_MAX_INIT = 5'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SCAN    = 2'd2,
        DONE    = 2'd3
    } hfe_state_e;

    function automatic logic [4:0] min5(input logic [4:0] a, input logic [4:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [4:0] max5(input logic [4:0] a, input logic [4:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hand_feature_extractor_pulse_sync_edge.sv
// Two-flop synchroniser for a level flag from the Pi domain, followed by a
// rising-edge detector. The edge output is a pure function of flops.
module pulse_sync_edge (
    input  logic slow_clk,
    input  logic dbnc_rst,
    input  logic async_in,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchroniser chain plus one-cycle history of the synchronised level.
    always_ff @(posedge slow_clk or posedge dbnc_rst) begin
        if (dbnc_rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign rise = sync_r & ~prev_r;

endmodule

// File: rtl/hand_feature_extractor.sv
// Scans a captured binary hand mask one pixel per clock and produces row/column
// counts, the total hand-pixel count and the inclusive bounding box, presented
// with a valid/ack handshake.
module hand_feature_extractor
    import hand_feature_extractor_pkg::*;
#(
    parameter int LENGTH = DEF_LENGTH,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                          slow_clk,
    input  logic                          dbnc_rst,
    input  logic                          image_ready,
    input  logic [LENGTH-1:0][WIDTH-1:0]  filtered_image,
    input  logic                          feat_ack,
    output logic                          busy,
    output logic                          feat_valid,
    output logic [LENGTH-1:0][4:0]        row_sum,
    output logic [WIDTH-1:0][4:0]         col_sum,
    output logic [CNT_W-1:0]              total,
    output logic [4:0]                    min_row,
    output logic [4:0]                    max_row,
    output logic [4:0]                    min_col,
    output logic [4:0]                    max_col,
    output logic                          empty
);

    localparam logic [4:0] LAST_ROW = 5'(LENGTH - 1);
    localparam logic [4:0] LAST_COL = 5'(WIDTH - 1);

    hfe_state_e                  state_r;
    hfe_state_e                  next_state_s;
    logic                        start_s;
    logic [LENGTH-1:0][WIDTH-1:0] snap_r;
    logic [4:0]                  row_r;
    logic [4:0]                  col_r;
    logic [4:0]                  trk_min_row_r;
    logic [4:0]                  trk_max_row_r;
    logic [4:0]                  trk_min_col_r;
    logic [4:0]                  trk_max_col_r;
    logic [4:0]                  trk_min_row_nx_s;
    logic [4:0]                  trk_max_row_nx_s;
    logic [4:0]                  trk_min_col_nx_s;
    logic [4:0]                  trk_max_col_nx_s;
    logic [CNT_W-1:0]            total_nx_s;
    logic                        pixel_s;
    logic                        last_pixel_s;
    logic                        scan_empty_s;

    pulse_sync_edge u_rdy_sync (
        .slow_clk (slow_clk),
        .dbnc_rst (dbnc_rst),
        .async_in (image_ready),
        .rise     (start_s)
    );

    assign pixel_s      = snap_r[row_r][col_r];
    assign last_pixel_s = (row_r == LAST_ROW) && (col_r == LAST_COL);

    // Tracker and total values including the pixel under examination, so the
    // final pixel is reflected when the results are published on entry to DONE.
    always_comb begin
        trk_min_row_nx_s = trk_min_row_r;
        trk_max_row_nx_s = trk_max_row_r;
        trk_min_col_nx_s = trk_min_col_r;
        trk_max_col_nx_s = trk_max_col_r;
        total_nx_s       = total;
        if (pixel_s) begin
            trk_min_row_nx_s = min5(trk_min_row_r, row_r);
            trk_max_row_nx_s = max5(trk_max_row_r, row_r);
            trk_min_col_nx_s = min5(trk_min_col_r, col_r);
            trk_max_col_nx_s = max5(trk_max_col_r, col_r);
            total_nx_s       = total + CNT_W'(1'b1);
        end else begin
            total_nx_s       = total;
        end
        scan_empty_s = (total_nx_s == {CNT_W{1'b0}});
    end

    // Next-state logic; start edges are honoured only from IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) next_state_s = CAPTURE;
                else         next_state_s = IDLE;
            end
            CAPTURE: next_state_s = SCAN;
            SCAN: begin
                if (last_pixel_s) next_state_s = DONE;
                else              next_state_s = SCAN;
            end
            DONE: begin
                if (feat_valid && feat_ack) next_state_s = IDLE;
                else                        next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge slow_clk or posedge dbnc_rst) begin
        if (dbnc_rst) state_r <= IDLE;
        else          state_r <= next_state_s;
    end

    // Snapshot, scan position, accumulators, trackers and registered outputs.
    always_ff @(posedge slow_clk or posedge dbnc_rst) begin
        if (dbnc_rst) begin
            snap_r        <= {(LENGTH*WIDTH){1'b0}};
            row_r         <= 5'd0;
            col_r         <= 5'd0;
            trk_min_row_r <= BBOX_MIN_INIT;
            trk_max_row_r <= BBOX_MAX_INIT;
            trk_min_col_r <= BBOX_MIN_INIT;
            trk_max_col_r <= BBOX_MAX_INIT;
            busy          <= 1'b0;
            feat_valid    <= 1'b0;
            row_sum       <= {(LENGTH*5){1'b0}};
            col_sum       <= {(WIDTH*5){1'b0}};
            total         <= {CNT_W{1'b0}};
            min_row       <= 5'd0;
            max_row       <= 5'd0;
            min_col       <= 5'd0;
            max_col       <= 5'd0;
            empty         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) busy <= 1'b1;
                end
                CAPTURE: begin
                    snap_r        <= filtered_image;
                    row_sum       <= {(LENGTH*5){1'b0}};
                    col_sum       <= {(WIDTH*5){1'b0}};
                    total         <= {CNT_W{1'b0}};
                    trk_min_row_r <= BBOX_MIN_INIT;
                    trk_max_row_r <= BBOX_MAX_INIT;
                    trk_min_col_r <= BBOX_MIN_INIT;
                    trk_max_col_r <= BBOX_MAX_INIT;
                    row_r         <= 5'd0;
                    col_r         <= 5'd0;
                    busy          <= 1'b1;
                end
                SCAN: begin
                    if (pixel_s) begin
                        row_sum[row_r] <= row_sum[row_r] + 5'd1;
                        col_sum[col_r] <= col_sum[col_r] + 5'd1;
                    end
                    total         <= total_nx_s;
                    trk_min_row_r <= trk_min_row_nx_s;
                    trk_max_row_r <= trk_max_row_nx_s;
                    trk_min_col_r <= trk_min_col_nx_s;
                    trk_max_col_r <= trk_max_col_nx_s;
                    if (col_r == LAST_COL) begin
                        col_r <= 5'd0;
                        row_r <= row_r + 5'd1;
                    end else begin
                        col_r <= col_r + 5'd1;
                    end
                    if (last_pixel_s) begin
                        busy       <= 1'b0;
                        feat_valid <= 1'b1;
                        empty      <= scan_empty_s;
                        min_row    <= scan_empty_s ? 5'd0 : trk_min_row_nx_s;
                        max_row    <= scan_empty_s ? 5'd0 : trk_max_row_nx_s;
                        min_col    <= scan_empty_s ? 5'd0 : trk_min_col_nx_s;
                        max_col    <= scan_empty_s ? 5'd0 : trk_max_col_nx_s;
                    end
                end
                DONE: begin
                    if (feat_valid && feat_ack) feat_valid <= 1'b0;
                end
                default: begin
                    busy       <= 1'b0;
                    feat_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hand_feature_extractor.sv
// Randomised and directed bench for hand_feature_extractor. Expected features
// are computed from the mask by a reference model and queued at start; a
// monitor pops and compares when feat_valid rises.
module tb_hand_feature_extractor;

    localparam int L  = 28;
    localparam int W  = 28;
    localparam int CW = 10;
    localparam int EXP_LAT = 788;

    typedef logic [L-1:0][W-1:0] mask_t;

    typedef struct packed {
        logic [L-1:0][4:0] rs;
        logic [W-1:0][4:0] cs;
        logic [CW-1:0]     tot;
        logic [4:0]        mnr;
        logic [4:0]        mxr;
        logic [4:0]        mnc;
        logic [4:0]        mxc;
        logic              emp;
    } feat_t;

    logic              slow_clk = 1'b0;
    logic              dbnc_rst = 1'b1;
    logic              image_ready = 1'b0;
    mask_t             filtered_image = '0;
    logic              feat_ack = 1'b0;
    logic              busy;
    logic              feat_valid;
    logic [L-1:0][4:0] row_sum;
    logic [W-1:0][4:0] col_sum;
    logic [CW-1:0]     total;
    logic [4:0]        min_row, max_row, min_col, max_col;
    logic              empty;

    feat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    logic  fv_d = 1'b0;

    always #5 slow_clk = ~slow_clk;

    hand_feature_extractor dut (
        .slow_clk       (slow_clk),
        .dbnc_rst       (dbnc_rst),
        .image_ready    (image_ready),
        .filtered_image (filtered_image),
        .feat_ack       (feat_ack),
        .busy           (busy),
        .feat_valid     (feat_valid),
        .row_sum        (row_sum),
        .col_sum        (col_sum),
        .total          (total),
        .min_row        (min_row),
        .max_row        (max_row),
        .min_col        (min_col),
        .max_col        (max_col),
        .empty          (empty)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference features straight from the mask: counts per row/column and
    // the first/last occupied row and column.
    function automatic feat_t model(input mask_t m);
        feat_t      f;
        logic [W-1:0] colmask;
        int rmin, rmax, cmin, cmax, tot, cnt;
        f = '0; colmask = '0;
        rmin = -1; rmax = -1; cmin = -1; cmax = -1; tot = 0;
        for (int r = 0; r < L; r++) begin
            cnt = $countones(m[r]);
            f.rs[r] = 5'(cnt);
            tot += cnt;
            if (cnt > 0) begin
                if (rmin < 0) rmin = r;
                rmax = r;
            end
            colmask |= m[r];
        end
        for (int c = 0; c < W; c++) begin
            cnt = 0;
            for (int r = 0; r < L; r++) cnt += int'(m[r][c]);
            f.cs[c] = 5'(cnt);
            if (colmask[c]) begin
                if (cmin < 0) cmin = c;
                cmax = c;
            end
        end
        f.tot = CW'(tot);
        f.emp = (tot == 0);
        if (tot > 0) begin
            f.mnr = 5'(rmin); f.mxr = 5'(rmax);
            f.mnc = 5'(cmin); f.mxc = 5'(cmax);
        end
        return f;
    endfunction

    task automatic compare_feat(input string tag, input feat_t e);
        check({tag, "_row_sum"}, 160'(row_sum), 160'(e.rs));
        check({tag, "_col_sum"}, 160'(col_sum), 160'(e.cs));
        check({tag, "_total"}, 160'(total), 160'(e.tot));
        check({tag, "_bbox"}, 160'({min_row, max_row, min_col, max_col}),
              160'({e.mnr, e.mxr, e.mnc, e.mxc}));
        check({tag, "_empty"}, 160'(empty), 160'(e.emp));
    endtask

    // Scoreboard monitor: every rising feat_valid consumes one expectation.
    always @(negedge slow_clk) begin
        if (feat_valid && !fv_d) begin
            if (exp_q.size() == 0) check("unexpected_valid", 160'(feat_valid), 160'(0));
            else                   compare_feat("scan", exp_q.pop_front());
        end
        fv_d <= feat_valid;
    end

    task automatic run_image(input mask_t m, input bit change_mid, input int hold, input bit toggle_rdy);
        feat_t e;
        int    lat;
        bit    got;
        @(negedge slow_clk);
        image_ready    = 1'b0;
        filtered_image = m;
        repeat (4) @(negedge slow_clk);
        e = model(m);
        exp_q.push_back(e);
        image_ready = 1'b1;
        lat = 0; got = 1'b0;
        while (!got && lat < 2000) begin
            @(negedge slow_clk);
            lat++;
            if (lat == 10) check("busy_in_scan", 160'(busy), 160'(1));
            if (change_mid && lat == 300) filtered_image = '1;
            if (feat_valid) got = 1'b1;
        end
        check("latency", 160'(lat), 160'(EXP_LAT));
        if (!got) void'(exp_q.pop_back());
        for (int i = 0; i < hold; i++) begin
            @(negedge slow_clk);
            if (toggle_rdy && i == 10) image_ready = 1'b0;
            if (toggle_rdy && i == 20) image_ready = 1'b1;
        end
        check("valid_held", 160'(feat_valid), 160'(1));
        check("busy_in_done", 160'(busy), 160'(0));
        compare_feat("hold", e);
        feat_ack = 1'b1;
        @(negedge slow_clk);
        feat_ack = 1'b0;
        check("valid_drop", 160'(feat_valid), 160'(0));
        compare_feat("after_ack", e);
        repeat (20) @(negedge slow_clk);
        check("no_retrigger", 160'({busy, feat_valid}), 160'(0));
    endtask

    function automatic mask_t rand_mask(input int dens);
        mask_t m;
        for (int r = 0; r < L; r++)
            for (int c = 0; c < W; c++)
                m[r][c] = ($urandom_range(0, 99) < dens);
        return m;
    endfunction

    initial begin
        mask_t m;
        bit    seen;

        // Reset state
        repeat (3) @(negedge slow_clk);
        check("rst_ctrl", 160'({busy, feat_valid, empty}), 160'(0));
        check("rst_sums", 160'({row_sum, col_sum}), 160'(0));
        check("rst_total_bbox", 160'({total, min_row, max_row, min_col, max_col}), 160'(0));
        dbnc_rst = 1'b0;
        repeat (3) @(negedge slow_clk);

        // All-zero, all-ones, single pixel
        m = '0;
        run_image(m, 1'b0, 5, 1'b0);
        m = '1;
        run_image(m, 1'b0, 5, 1'b0);
        m = '0; m[3][5] = 1'b1;
        run_image(m, 1'b0, 5, 1'b0);

        // Rectangle, mask overwritten mid-scan
        m = '0;
        for (int r = 10; r <= 14; r++)
            for (int c = 2; c <= 20; c++) m[r][c] = 1'b1;
        run_image(m, 1'b1, 5, 1'b0);

        // Reset at SCAN cycle 100 aborts, then a clean rerun
        @(negedge slow_clk);
        image_ready = 1'b0;
        filtered_image = '1;
        repeat (4) @(negedge slow_clk);
        image_ready = 1'b1;
        repeat (103) @(negedge slow_clk);
        check("abort_busy_before", 160'(busy), 160'(1));
        dbnc_rst = 1'b1;
        image_ready = 1'b0;
        #1;
        check("abort_ctrl", 160'({busy, feat_valid, empty}), 160'(0));
        check("abort_sums", 160'({row_sum, col_sum}), 160'(0));
        check("abort_total_bbox", 160'({total, min_row, max_row, min_col, max_col}), 160'(0));
        repeat (3) @(negedge slow_clk);
        dbnc_rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 900; i++) begin
            @(negedge slow_clk);
            if (feat_valid) seen = 1'b1;
        end
        check("abort_no_valid", 160'(seen), 160'(0));
        m = '0; m[3][5] = 1'b1;
        run_image(m, 1'b0, 5, 1'b0);

        // Long hold with image_ready toggled during DONE
        run_image(rand_mask(30), 1'b0, 50, 1'b1);

        // Randomised masks at several densities, including sparse edges
        run_image(rand_mask(1), 1'b0, 3, 1'b0);
        run_image(rand_mask(10), 1'b0, 3, 1'b0);
        run_image(rand_mask(50), 1'b0, 3, 1'b0);
        run_image(rand_mask(90), 1'b0, 3, 1'b0);
        m = '0; m[0][27] = 1'b1; m[27][0] = 1'b1;
        run_image(m, 1'b0, 3, 1'b0);

        check("scoreboard_drained", 160'(exp_q.size()), 160'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
